// File: rtl/exunit_mul_pkg.sv
// Shared constants and operation encoding for the RV32M multiply execution unit.
// The RV32 width and op-select width macros are defined here once for the whole slice.
`ifndef MUL_OP_SEL
`define MUL_OP_SEL 2
`endif
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif

package exunit_mul_pkg;

   localparam int DATA_W   = `RV32_DATA_WIDTH;
   localparam int MUL_OP_W = `MUL_OP_SEL;

   typedef enum logic [MUL_OP_W-1:0] {
      MUL_OP_MUL    = 2'd0,
      MUL_OP_MULH   = 2'd1,
      MUL_OP_MULHSU = 2'd2,
      MUL_OP_MULHU  = 2'd3
   } mul_op_e;

endpackage

// File: rtl/exunit_mul_if.sv
// Issue and writeback handshake between the issue stage and the multiply unit.
interface exunit_mul_if #(
   parameter int TAG_W = 6
) ();
   import exunit_mul_pkg::*;

   logic              o_accessable;
   logic              i_is_vld;
   mul_op_e           i_op_sel;
   logic [DATA_W-1:0] i_rs1;
   logic [DATA_W-1:0] i_rs2;
   logic [TAG_W-1:0]  i_tag;
   logic              o_exfin;
   logic [TAG_W-1:0]  o_exfin_tag;
   logic [DATA_W-1:0] o_exfin_res;
   logic              i_exfin_ack;

   modport slave (
      output o_accessable, o_exfin, o_exfin_tag, o_exfin_res,
      input  i_is_vld, i_op_sel, i_rs1, i_rs2, i_tag, i_exfin_ack
   );

   modport master (
      input  o_accessable, o_exfin, o_exfin_tag, o_exfin_res,
      output i_is_vld, i_op_sel, i_rs1, i_rs2, i_tag, i_exfin_ack
   );
endinterface

// File: rtl/exunit_mul_core.sv
// Combinational RV32M multiplier: operand extension, signed product, high/low select.
module exunit_mul_core
   import exunit_mul_pkg::*;
(
   input  mul_op_e           op,
   input  logic [DATA_W-1:0] rs1,
   input  logic [DATA_W-1:0] rs2,
   output logic [DATA_W-1:0] res
);
   logic signed [DATA_W:0]     ext_a;
   logic signed [DATA_W:0]     ext_b;
   logic signed [2*DATA_W-1:0] prod;

   // Only the low 64 bits of the 66-bit signed product are ever selected.
   always_comb begin
      ext_a = {((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU)) & rs1[DATA_W-1], rs1};
      ext_b = {(op == MUL_OP_MULH) & rs2[DATA_W-1], rs2};
      prod  = (2*DATA_W)'(ext_a) * (2*DATA_W)'(ext_b);
      res   = (op == MUL_OP_MUL) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
   end
endmodule

// File: rtl/exunit_mul.sv
// Pipelined RV32M multiply unit with tag carry and writeback backpressure.
// Optional flush port enabled by EXUNIT_MUL_FLUSH_EN.
module exunit_mul
   import exunit_mul_pkg::*;
#(
   parameter int STAGES = 3,
   parameter int TAG_W  = 6
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef EXUNIT_MUL_FLUSH_EN
   input  logic        i_flush,
`endif
   exunit_mul_if.slave bus
);
   logic              stall;
   logic [STAGES-1:0] vld_p;
   logic [TAG_W-1:0]  tag_p [STAGES];
   mul_op_e           core_op;
   logic [DATA_W-1:0] core_rs1;
   logic [DATA_W-1:0] core_rs2;
   logic [DATA_W-1:0] core_res;
   logic [DATA_W-1:0] final_res;

   assign stall            = vld_p[STAGES-1] & ~bus.i_exfin_ack;
   assign bus.o_accessable = ~stall;

   // Valid chain: rigid shift register, held as a whole while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p <= '0;
`ifdef EXUNIT_MUL_FLUSH_EN
      end else if (i_flush) begin
         vld_p <= '0;
`endif
      end else if (!stall) begin
         vld_p[0] <= bus.i_is_vld;
         for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!stall) begin
         tag_p[0] <= bus.i_tag;
         for (int i = 1; i < STAGES; i++) tag_p[i] <= tag_p[i-1];
      end
   end

   exunit_mul_core u_core (
      .op  (core_op),
      .rs1 (core_rs1),
      .rs2 (core_rs2),
      .res (core_res)
   );

   generate
      if (STAGES == 1) begin : g_single
         logic [DATA_W-1:0] res_p0;

         assign core_op  = bus.i_op_sel;
         assign core_rs1 = bus.i_rs1;
         assign core_rs2 = bus.i_rs2;

         always_ff @(posedge clk) begin
            if (!stall) res_p0 <= core_res;
         end

         assign final_res = res_p0;
      end else begin : g_multi
         mul_op_e           op_p0;
         logic [DATA_W-1:0] rs1_p0;
         logic [DATA_W-1:0] rs2_p0;
         logic [DATA_W-1:0] res_p [1:STAGES-1];

         assign core_op  = op_p0;
         assign core_rs1 = rs1_p0;
         assign core_rs2 = rs2_p0;

         // Slot 0 holds operands; the multiply sits between slot 0 and slot 1.
         always_ff @(posedge clk) begin
            if (!stall) begin
               op_p0    <= bus.i_op_sel;
               rs1_p0   <= bus.i_rs1;
               rs2_p0   <= bus.i_rs2;
               res_p[1] <= core_res;
               for (int i = 2; i < STAGES; i++) res_p[i] <= res_p[i-1];
            end
         end

         assign final_res = res_p[STAGES-1];
      end
   endgenerate

   // Data registers are unreset; outputs read 0 whenever nothing is presented.
   assign bus.o_exfin     = vld_p[STAGES-1];
   assign bus.o_exfin_tag = vld_p[STAGES-1] ? tag_p[STAGES-1] : '0;
   assign bus.o_exfin_res = vld_p[STAGES-1] ? final_res : '0;
endmodule

// File: tb/tb_exunit_mul.sv
// Self-checking bench for exunit_mul: directed scenarios plus random traffic
// against a queue-based reference model of in-flight operations.
module tb_exunit_mul;
   import exunit_mul_pkg::*;

`ifdef EXUNIT_MUL_FLUSH_EN
   localparam int STAGES = 4;
`else
   localparam int STAGES = 3;
`endif
   localparam int TAG_W = 6;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [31:0]      res;
      int               age;
   } op_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             vld = 1'b0;
   mul_op_e          op = MUL_OP_MUL;
   logic [31:0]      rs1 = '0;
   logic [31:0]      rs2 = '0;
   logic [TAG_W-1:0] tag_in = '0;
   logic             ack = 1'b1;
   logic             flush = 1'b0;

   int               n_assert = 0;
   int               n_fail = 0;
   op_t              q[$];
   logic [31:0]      got_res[$];
   logic [TAG_W-1:0] got_tag[$];

   exunit_mul_if #(.TAG_W(TAG_W)) bus ();

   assign bus.i_is_vld    = vld;
   assign bus.i_op_sel    = op;
   assign bus.i_rs1       = rs1;
   assign bus.i_rs2       = rs2;
   assign bus.i_tag       = tag_in;
   assign bus.i_exfin_ack = ack;

   exunit_mul #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
`ifdef EXUNIT_MUL_FLUSH_EN
      .i_flush (flush),
`endif
      .bus     (bus)
   );

   initial forever #5 clk = ~clk;

   // Architectural result from the extension rules, using 64-bit integer arithmetic.
   function automatic logic [31:0] ref_mul(mul_op_e o, logic [31:0] a, logic [31:0] b);
      longint sa, sb, p;
      sa = (o == MUL_OP_MULH || o == MUL_OP_MULHSU) ? longint'($signed(a)) : longint'({32'b0, a});
      sb = (o == MUL_OP_MULH) ? longint'($signed(b)) : longint'({32'b0, b});
      p  = sa * sb;
      return (o == MUL_OP_MUL) ? p[31:0] : p[63:32];
   endfunction

   task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic bit model_presents();
      return (q.size() > 0) && (q[0].age == STAGES);
   endfunction

   task automatic check_outputs();
      bit ev;
      ev = model_presents();
      chk("exfin", 32'(bus.o_exfin), 32'(ev));
      chk("accessable", 32'(bus.o_accessable), 32'(!(ev && !ack)));
      if (ev) begin
         chk("exfin_tag", 32'(bus.o_exfin_tag), 32'(q[0].tag));
         chk("exfin_res", bus.o_exfin_res, q[0].res);
      end
   endtask

   // One clock: advance the model with the inputs seen at the edge, then check.
   task automatic tick();
      bit ev, stall_m;
      ev      = model_presents();
      stall_m = ev && !ack;
      if (ev && ack && rst_n && !flush) begin
         got_res.push_back(bus.o_exfin_res);
         got_tag.push_back(bus.o_exfin_tag);
      end
      @(posedge clk);
      if (!rst_n || flush) q.delete();
      else if (!stall_m) begin
         if (ev) void'(q.pop_front());
         foreach (q[i]) q[i].age++;
         if (vld) q.push_back('{tag_in, ref_mul(op, rs1, rs2), 1});
      end
      #1;
      check_outputs();
   endtask

   task automatic issue(mul_op_e o, logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] t);
      vld = 1'b1; op = o; rs1 = a; rs2 = b; tag_in = t;
      tick();
      vld = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      // Reset
      rst_n = 1'b0;
      tick(); tick();
      chk("rst_exfin_tag", 32'(bus.o_exfin_tag), 32'd0);
      chk("rst_exfin_res", bus.o_exfin_res, 32'd0);
      rst_n = 1'b1;
      tick();

      // Single MUL, exact latency
      issue(MUL_OP_MUL, 32'd7, 32'd6, 6'd5);
      for (int c = 1; c <= STAGES + 2; c++) begin
         if (c > 1) tick();
         chk("t1_exfin_cycle", 32'(bus.o_exfin), 32'(c == STAGES));
         if (c == STAGES) begin
            chk("t1_res", bus.o_exfin_res, 32'd42);
            chk("t1_tag", 32'(bus.o_exfin_tag), 32'd5);
         end
      end

      // High-half variants
      got_res.delete(); got_tag.delete();
      issue(MUL_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd10);
      issue(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 6'd11);
      issue(MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd12);
      idle(STAGES + 2);
      chk("t2_count", 32'(got_res.size()), 32'd3);
      if (got_res.size() == 3) begin
         chk("t2_mulh",   got_res[0], 32'h0000_0000);
         chk("t2_mulhsu", got_res[1], 32'hFFFF_FFFF);
         chk("t2_mulhu",  got_res[2], 32'hFFFF_FFFE);
      end

      // Back-to-back ordering
      got_res.delete(); got_tag.delete();
      issue(MUL_OP_MUL, 32'd3, 32'd3, 6'd1);
      issue(MUL_OP_MUL, 32'd4, 32'd4, 6'd2);
      issue(MUL_OP_MUL, 32'd5, 32'd5, 6'd3);
      idle(STAGES + 2);
      chk("t3_count", 32'(got_tag.size()), 32'd3);
      if (got_tag.size() == 3) begin
         chk("t3_tag0", 32'(got_tag[0]), 32'd1);
         chk("t3_tag1", 32'(got_tag[1]), 32'd2);
         chk("t3_tag2", 32'(got_tag[2]), 32'd3);
      end

      // Backpressure: hold tag 1 for 4 cycles
      issue(MUL_OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 6'd1);
      issue(MUL_OP_MULH,  32'h8000_0000, 32'h7FFF_FFFF, 6'd2);
      begin
         int waited = 0;
         while (!bus.o_exfin && waited < 20) begin tick(); waited++; end
         chk("t4_wait_bound", 32'(bus.o_exfin), 32'd1);
      end
      ack = 1'b0;
      #1;
      chk("t4_accessable_now", 32'(bus.o_accessable), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_hold_exfin", 32'(bus.o_exfin), 32'd1);
         chk("t4_hold_tag", 32'(bus.o_exfin_tag), 32'd1);
         chk("t4_hold_acc", 32'(bus.o_accessable), 32'd0);
      end
      ack = 1'b1;
      tick();
      chk("t4_next_tag", 32'(bus.o_exfin_tag), 32'd2);
      idle(STAGES + 1);

      // Reset with ops in flight
      issue(MUL_OP_MUL, 32'd9, 32'd9, 6'd20);
      issue(MUL_OP_MUL, 32'd8, 32'd8, 6'd21);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < STAGES + 3; i++) begin
         tick();
         chk("t5_no_stale", 32'(bus.o_exfin), 32'd0);
      end

`ifdef EXUNIT_MUL_FLUSH_EN
      // Flush coinciding with a second issue
      issue(MUL_OP_MUL, 32'd2, 32'd2, 6'd1);
      flush = 1'b1;
      issue(MUL_OP_MUL, 32'd3, 32'd2, 6'd2);
      flush = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t6_flushed", 32'(bus.o_exfin), 32'd0);
      end
      issue(MUL_OP_MUL, 32'd11, 32'd3, 6'd9);
      for (int c = 1; c <= STAGES; c++) begin
         if (c > 1) tick();
         chk("t6_after_exfin", 32'(bus.o_exfin), 32'(c == STAGES));
      end
      chk("t6_after_res", bus.o_exfin_res, 32'd33);
      idle(2);
`endif

      // Random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         vld    = ($urandom_range(0, 3) != 0) && bus.o_accessable;
         op     = mul_op_e'($urandom_range(0, 3));
         rs1    = $urandom;
         rs2    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         tag_in = TAG_W'($urandom);
         ack    = ($urandom_range(0, 9) < 7);
`ifdef EXUNIT_MUL_FLUSH_EN
         flush  = ($urandom_range(0, 31) == 0);
`endif
         tick();
      end
      vld = 1'b0; ack = 1'b1; flush = 1'b0;
      idle(STAGES + 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/exunit_mul.md
Name: exunit_mul

Overview:
- Pipelined RV32M multiply execution unit (MUL/MULH/MULHSU/MULHU).
- Sits beside the single-cycle ALU unit behind the issue stage.
- Parametrised latency; carries a result tag (ROB/RS entry) through the pipe.
- Adds writeback backpressure: a result holds until the writeback bus accepts it, and the whole pipe stalls meanwhile.

Parameters:
- STAGES, 3: issue-to-result latency in cycles without stall; legal range 1..8.
- TAG_W, 6: width of the tag carried with each operation.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- o_accessable  out  1  unit can accept an issue this cycle
- i_is_vld  in  1  issue valid; sampled only when o_accessable=1
- i_op_sel  in  `MUL_OP_SEL  operation: MUL, MULH, MULHSU, MULHU
- i_rs1  in  `RV32_DATA_WIDTH  operand 1
- i_rs2  in  `RV32_DATA_WIDTH  operand 2
- i_tag  in  TAG_W  destination tag
- i_flush  in  1  kill all in-flight ops (present only with EXUNIT_MUL_FLUSH_EN)
- o_exfin  out  1  result valid
- o_exfin_tag  out  TAG_W  tag of presented result
- o_exfin_res  out  `RV32_DATA_WIDTH  result
- i_exfin_ack  in  1  writeback accepted result this cycle

Behaviour:
- Reset (rst_n=0 at posedge clk) clears all stage valid bits.
  - o_exfin=0.
  - o_accessable=1 when not stalled.
  - o_exfin_tag and o_exfin_res are don't-care but driven 0 from reset.
- Data and tag registers need no reset. Reset mid-operation discards every in-flight op; no result is produced for it.
- Pipe: STAGES register slots, slot[0]..slot[STAGES-1]. Each slot holds valid, tag, op, and either operands or a partial/full product. o_exfin = slot[STAGES-1].valid.
- stall = o_exfin & ~i_exfin_ack. o_accessable = ~stall (combinational).
- No stall: every slot shifts forward one position each cycle.
  - slot[0] loads {i_is_vld, i_tag, op, operands}.
  - The issue-to-o_exfin latency is exactly STAGES cycles.
  - Throughput is 1 op/cycle.
- Stall: all slots hold. An issue presented while o_accessable=0 is ignored; the issue stage must not assert it.
- Bubbles do not compress during stall; the pipe is a rigid shift register.
- Arithmetic:
  - Operands are extended to 33 bits: rs1 signed for MULH and MULHSU; rs2 signed for MULH only; zero-extended otherwise.
  - The product is the 66-bit signed product of the extended operands.
  - MUL returns prod[31:0]. MULH, MULHSU and MULHU return prod[63:32].
- Multiplication is performed combinationally between slot[0] and slot[1]. The remaining slots only carry the result (retiming-friendly).
- STAGES=1: slot[0] registers the final result directly; latency is 1.
- Same-cycle i_exfin_ack and i_is_vld: the pipe shifts, the result retires, and the new op enters slot[0].
- i_exfin_ack while o_exfin=0 is ignored.

Optional Feature:
- Macro EXUNIT_MUL_FLUSH_EN.
- Defined:
  - i_flush exists.
  - i_flush=1 at a posedge clears all slot valid bits; it has priority over shift and stall.
  - A simultaneous i_is_vld op is also dropped.
  - o_exfin=0 the next cycle.
- Undefined: the i_flush port is absent and the pipe is never flushed except by reset.

Decomposition:
- constants.vh holds:
  - MUL_OP_SEL width (2).
  - Encodings MUL_OP_MUL=0, MUL_OP_MULH=1, MUL_OP_MULHSU=2, MUL_OP_MULHU=3.
  - RV32_DATA_WIDTH, which is already present.
- Sub-module mul_core: combinational; op plus two 32-bit operands in, 32-bit selected result out. This keeps the extension and high/low select testable in isolation.

Test Plan:
1. STAGES=3. Issue MUL rs1=7, rs2=6, tag=5 at cycle 0, ack held 1 → o_exfin=1 at cycle 3 only, res=42, tag=5.
2. Issue MULH 0xFFFFFFFF×0xFFFFFFFF, MULHSU 0xFFFFFFFF×0x00000002, MULHU 0xFFFFFFFF×0xFFFFFFFF → res 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE.
3. Issue back-to-back tags 1,2,3, ack=1 → results on three consecutive cycles, in order, tags 1,2,3.
4. Issue tags 1,2 back-to-back, hold ack=0 for 4 cycles once tag 1 is presented:
   - o_exfin and tag=1 stay stable; o_accessable=0.
   - Raising ack gives tag 2 the next cycle.
5. Assert rst_n=0 with two ops in flight → o_exfin=0 for all following cycles; no stale result appears.
6. EXUNIT_MUL_FLUSH_EN, STAGES=4. Issue tags 1,2, pulse i_flush the cycle tag 2 issues → no o_exfin in the next 6 cycles; a later issue completes normally after 4 cycles.
